// File: rtl/id_stage_param.sv
// Instruction-decode stage with integrated ID/EX pipeline register.
// Decodes the IF/ID instruction, reads a reset-clearable register file with
// write-back bypass, resolves beq/bne/j in ID and launches a registered
// bundle to EX. Stall and flush turn the launched bundle into a bubble.
//
// Ports:
//   clk, reset (async, active-low)
//   id_valid, pc_plus4, instr                     : IF/ID register contents
//   wb_reg_write, wb_write_reg_addr,
//   wb_write_back_data                            : write-back port
//   stall, flush                                  : hazard controls
//   branch_taken, branch_address, jump,
//   jump_address                                  : combinational redirect
//   ex_*                                          : registered ID/EX bundle
module id_stage_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [31:0]       instr,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_write_reg_addr,
  input  logic [DATA_W-1:0] wb_write_back_data,
  input  logic              stall,
  input  logic              flush,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_address,
  output logic              jump,
  output logic [PC_W-1:0]   jump_address,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_dest_reg,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op
);

  localparam int unsigned NREG = 2 ** RA_W;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
  } ctrl_t;

  logic [5:0]        opcode;
  logic [RA_W-1:0]   rs_addr;
  logic [RA_W-1:0]   rt_addr;
  logic [RA_W-1:0]   rd_addr;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              wb_active;
  logic              issue;
  logic              equal;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] regs [NREG];

  assign opcode  = instr[31:26];
  assign rs_addr = instr[21 +: RA_W];
  assign rt_addr = instr[16 +: RA_W];
  assign rd_addr = instr[11 +: RA_W];
  assign imm     = DATA_W'($signed(instr[15:0]));

  // Opcode decode into the control word.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = 2'b01;
        ctrl.is_beq = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = 2'b01;
        ctrl.is_bne = 1'b1;
      end
      OP_J:    ctrl.is_j = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Register file; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wb_active) begin
      regs[wb_write_reg_addr] <= wb_write_back_data;
    end
  end

  // Reads see the write-back data in the same cycle it is being written.
  assign wb_active = wb_reg_write && (wb_write_reg_addr != '0);

  always_comb begin
    rdata1 = regs[rs_addr];
    rdata2 = regs[rt_addr];
    if (wb_active && (wb_write_reg_addr == rs_addr)) rdata1 = wb_write_back_data;
    if (wb_active && (wb_write_reg_addr == rt_addr)) rdata2 = wb_write_back_data;
    if (rs_addr == '0) rdata1 = '0;
    if (rt_addr == '0) rdata2 = '0;
  end

  // Branch/jump resolution in ID.
  assign issue          = id_valid && !stall && !flush;
  assign equal          = (rdata1 == rdata2);
  assign branch_taken   = issue && ((ctrl.is_beq && equal) || (ctrl.is_bne && !equal));
  assign jump           = issue && ctrl.is_j;
  assign branch_address = pc_plus4 + PC_W'({{14{instr[15]}}, instr[15:0], 2'b00});
  assign jump_address   = {instr[PC_W-3:0], 2'b00};

  // ID/EX register; a bubble clears valid and controls, data fields still load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_reg1       <= '0;
      ex_reg2       <= '0;
      ex_imm        <= '0;
      ex_dest_reg   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else begin
      ex_valid      <= issue;
      ex_reg1       <= rdata1;
      ex_reg2       <= rdata2;
      ex_imm        <= imm;
      ex_dest_reg   <= ctrl.reg_dst ? rd_addr : rt_addr;
      ex_rs         <= rs_addr;
      ex_rt         <= rt_addr;
      ex_mem_to_reg <= issue && ctrl.mem_to_reg;
      ex_mem_read   <= issue && ctrl.mem_read;
      ex_mem_write  <= issue && ctrl.mem_write;
      ex_alu_src    <= issue && ctrl.alu_src;
      ex_reg_write  <= issue && ctrl.reg_write;
      ex_alu_op     <= issue ? ctrl.alu_op : 2'b00;
    end
  end

endmodule

// File: tb/tb_id_stage_param.sv
// Testbench for id_stage_param: table of vectors with hand-computed expected
// values, ID/EX bundle expectations queued at drive time and checked when the
// registered outputs appear, plus reset and stall sequences.
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [9:0]  pc_plus4;
  logic [31:0] instr;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg_addr;
  logic [31:0] wb_write_back_data;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [9:0]  branch_address;
  logic        jump;
  logic [9:0]  jump_address;
  logic        ex_valid;
  logic [31:0] ex_reg1, ex_reg2, ex_imm;
  logic [4:0]  ex_dest_reg, ex_rs, ex_rt;
  logic        ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;

  id_stage_param #(.DATA_W(32), .PC_W(10), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .pc_plus4(pc_plus4),
    .instr(instr), .wb_reg_write(wb_reg_write),
    .wb_write_reg_addr(wb_write_reg_addr), .wb_write_back_data(wb_write_back_data),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_address(branch_address), .jump(jump), .jump_address(jump_address),
    .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_imm(ex_imm),
    .ex_dest_reg(ex_dest_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  // ctrl = {mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op[1:0]}
  localparam logic [6:0] C_R  = 7'b0000110;
  localparam logic [6:0] C_LW = 7'b1101100;
  localparam logic [6:0] C_SW = 7'b0011000;
  localparam logic [6:0] C_AI = 7'b0001100;
  localparam logic [6:0] C_BR = 7'b0000001;
  localparam logic [6:0] C_0  = 7'b0000000;

  typedef struct {
    logic        valid;
    logic [31:0] r1, r2, imm;
    logic [4:0]  dest, rs, rt;
    logic [6:0]  ctrl;
  } exp_t;

  typedef struct {
    logic        idv, stl, fls, wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [31:0] ins;
    logic [9:0]  pc4;
    logic        ebt, ej;
    int          ca;      // 0: no address check, 1: branch_address, 2: jump_address
    logic [9:0]  ea;
    exp_t        ex;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic idv, input logic stl, input logic fls, input logic wbe,
    input logic [4:0] wba, input logic [31:0] wbd, input logic [31:0] ins,
    input logic [9:0] pc4, input logic ebt, input logic ej, input int ca,
    input logic [9:0] ea, input logic ev, input logic [31:0] r1,
    input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] dest,
    input logic [4:0] rs, input logic [4:0] rt, input logic [6:0] ctrl);
    vec_t v;
    v.idv = idv; v.stl = stl; v.fls = fls; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.ins = ins; v.pc4 = pc4; v.ebt = ebt; v.ej = ej; v.ca = ca; v.ea = ea;
    v.ex.valid = ev; v.ex.r1 = r1; v.ex.r2 = r2; v.ex.imm = imm;
    v.ex.dest = dest; v.ex.rs = rs; v.ex.rt = rt; v.ex.ctrl = ctrl;
    return v;
  endfunction

  task automatic check_bundle(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " ex_valid"}, 32'(ex_valid), 32'(e.valid));
    check({tag, " ex_reg1"}, ex_reg1, e.r1);
    check({tag, " ex_reg2"}, ex_reg2, e.r2);
    check({tag, " ex_imm"}, ex_imm, e.imm);
    check({tag, " ex_dest_reg"}, 32'(ex_dest_reg), 32'(e.dest));
    check({tag, " ex_rs"}, 32'(ex_rs), 32'(e.rs));
    check({tag, " ex_rt"}, 32'(ex_rt), 32'(e.rt));
    check({tag, " ex_ctrl"},
          32'({ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op}),
          32'(e.ctrl));
  endtask

  // One cycle: drive at negedge, check combinational outputs, queue the
  // expected bundle, then check the registered bundle just after posedge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    id_valid = v.idv; stall = v.stl; flush = v.fls;
    wb_reg_write = v.wbe; wb_write_reg_addr = v.wba; wb_write_back_data = v.wbd;
    instr = v.ins; pc_plus4 = v.pc4;
    #1;
    check({tag, " branch_taken"}, 32'(branch_taken), 32'(v.ebt));
    check({tag, " jump"}, 32'(jump), 32'(v.ej));
    if (v.ca == 1) check({tag, " branch_address"}, 32'(branch_address), 32'(v.ea));
    if (v.ca == 2) check({tag, " jump_address"}, 32'(jump_address), 32'(v.ea));
    sb.push_back(v.ex);
    @(posedge clk);
    #1;
    check_bundle(tag);
  endtask

  task automatic check_ex_zero(input string tag);
    check({tag, " ex_valid"}, 32'(ex_valid), 32'd0);
    check({tag, " ex_reg1"}, ex_reg1, 32'd0);
    check({tag, " ex_imm"}, ex_imm, 32'd0);
    check({tag, " ex_dest_reg"}, 32'(ex_dest_reg), 32'd0);
    check({tag, " ex_ctrl"},
          32'({ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op}),
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; pc_plus4 = '0; instr = '0;
    wb_reg_write = 1'b0; wb_write_reg_addr = '0; wb_write_back_data = '0;
    stall = 1'b0; flush = 1'b0;

    // Reset held for 3 cycles, then released with a bubble in ID.
    repeat (3) @(posedge clk);
    #1;
    check_ex_zero("in_reset");
    @(negedge clk);
    reset = 1'b1;
    apply(mk(0,0,0,0, 0,0, 32'h0, 10'h0, 0,0,0,10'h0,
             0, 0,0,32'h0, 0,0,0, C_0), "post_reset");

    // All registers read back as zero after reset.
    for (int i = 1; i < 32; i++) begin
      logic [4:0]  a;
      logic [31:0] ins;
      a   = 5'(i);
      ins = {6'h00, a, a, 5'd0, 11'h020};
      apply(mk(1,0,0,0, 0,0, ins, 10'h0, 0,0,0,10'h0,
               1, 32'h0,32'h0,32'h20, 5'd0,a,a, C_R), "rf_clear");
    end

    //        idv stl fls wbe wba wbd           instr         pc4    bt j  ca ea      v  r1            r2            imm           dst rs rt ctrl
    tbl.push_back(mk(1,0,0,1, 5, 32'hDEADBEEF, 32'h00A01820, 10'h0,  0,0,0,10'h0,   1, 32'hDEADBEEF, 32'h0,        32'h00001820, 3, 5, 0, C_R));
    tbl.push_back(mk(1,0,0,1, 0, 32'h00001234, 32'h00052020, 10'h0,  0,0,0,10'h0,   1, 32'h0,        32'hDEADBEEF, 32'h00002020, 4, 0, 5, C_R));
    tbl.push_back(mk(0,0,0,1, 1, 32'd7,        32'h00000000, 10'h0,  0,0,0,10'h0,   0, 32'h0,        32'h0,        32'h0,        0, 0, 0, C_0));
    tbl.push_back(mk(1,0,0,1, 2, 32'd7,        32'h10220004, 10'h010,1,0,1,10'h020, 1, 32'd7,        32'd7,        32'h4,        2, 1, 2, C_BR));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'h14220004, 10'h010,0,0,1,10'h020, 1, 32'd7,        32'd7,        32'h4,        2, 1, 2, C_BR));
    tbl.push_back(mk(1,0,0,1, 2, 32'd8,        32'h14220004, 10'h010,1,0,1,10'h020, 1, 32'd7,        32'd8,        32'h4,        2, 1, 2, C_BR));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'h08000040, 10'h010,0,1,2,10'h100, 1, 32'h0,        32'h0,        32'h40,       0, 0, 0, C_0));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'h10210001, 10'h3FC,1,0,1,10'h000, 1, 32'd7,        32'd7,        32'h1,        1, 1, 1, C_BR));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'h1021FFFE, 10'h010,1,0,1,10'h008, 1, 32'd7,        32'd7,        32'hFFFFFFFE, 1, 1, 1, C_BR));
    tbl.push_back(mk(1,0,1,0, 0, 32'h0,        32'h10210004, 10'h010,0,0,1,10'h020, 0, 32'd7,        32'd7,        32'h4,        1, 1, 1, C_0));
    tbl.push_back(mk(1,1,0,0, 0, 32'h0,        32'h10210004, 10'h010,0,0,1,10'h020, 0, 32'd7,        32'd7,        32'h4,        1, 1, 1, C_0));
    tbl.push_back(mk(1,1,0,0, 0, 32'h0,        32'h08000040, 10'h010,0,0,0,10'h0,   0, 32'h0,        32'h0,        32'h40,       0, 0, 0, C_0));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'hAC220008, 10'h0,  0,0,0,10'h0,   1, 32'd7,        32'd8,        32'h8,        2, 1, 2, C_SW));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'h2026FFFF, 10'h0,  0,0,0,10'h0,   1, 32'd7,        32'h0,        32'hFFFFFFFF, 6, 1, 6, C_AI));
    tbl.push_back(mk(1,0,0,0, 0, 32'h0,        32'hFC220008, 10'h0,  0,0,0,10'h0,   1, 32'd7,        32'd8,        32'h8,        2, 1, 2, C_0));
    tbl.push_back(mk(1,1,1,0, 0, 32'h0,        32'h2026FFFF, 10'h0,  0,0,0,10'h0,   0, 32'd7,        32'h0,        32'hFFFFFFFF, 6, 1, 6, C_0));
    tbl.push_back(mk(1,0,0,1, 6, 32'h000055AA, 32'h00264820, 10'h0,  0,0,0,10'h0,   1, 32'd7,        32'h000055AA, 32'h00004820, 9, 1, 6, C_R));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // lw held by a 2-cycle stall: two bubbles, then it issues.
    apply(mk(1,1,0,0, 0,0, 32'h8C270004, 10'h0, 0,0,0,10'h0,
             0, 32'd7,32'h0,32'h4, 7,1,7, C_0), "lw_stall1");
    apply(mk(1,1,0,0, 0,0, 32'h8C270004, 10'h0, 0,0,0,10'h0,
             0, 32'd7,32'h0,32'h4, 7,1,7, C_0), "lw_stall2");
    apply(mk(1,0,0,0, 0,0, 32'h8C270004, 10'h0, 0,0,0,10'h0,
             1, 32'd7,32'h0,32'h4, 7,1,7, C_LW), "lw_issue");

    // Asynchronous reset between edges clears EX outputs and the file.
    apply(mk(1,0,0,0, 0,0, 32'h00A01820, 10'h0, 0,0,0,10'h0,
             1, 32'hDEADBEEF,32'h0,32'h00001820, 3,5,0, C_R), "pre_mid_reset");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_ex_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1,0,0,0, 0,0, 32'h00A01820, 10'h0, 0,0,0,10'h0,
             1, 32'h0,32'h0,32'h00001820, 3,5,0, C_R), "rf_after_mid_reset");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
